chan_err_inj: RTL

- Parametrised noisy-channel model that sits between the convolutional encoder output and the Viterbi decoder input in the tx/rx test harness.
- Corrupts W-bit code symbols with programmable error bursts, either periodic or LFSR-random.
- Flags which bits were flipped and counts injected bit errors over a programmable symbol window, so decoder BER can be measured.
- Generalises the fixed 2-bit, fixed-phase, every-cycle injector: counts valid symbols only, and adds burst length, bit mask, random mode and windowed error counting.

---
 rtl/chan_pkg.sv | 37 +++
 rtl/lfsr8.sv | 43 ++++
 rtl/chan_err_inj.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/chan_pkg.sv
`default_nettype none
// ============================================================================
// Module   : chan_pkg
// Brief    : Shared types, constants and helpers for the channel error
//            injector (mode and FSM encodings, LFSR taps, popcount).
// Revision : 1.0 - initial release
// ============================================================================
package chan_pkg;

  // Injection mode as presented on mode_i; 2'b11 is handled as off
  typedef enum logic [1:0] {
    MODE_OFF = 2'b00,
    MODE_PER = 2'b01,
    MODE_RND = 2'b10
  } mode_e;

  // Burst FSM states
  typedef enum logic [0:0] {
    CLEAN = 1'b0,
    BURST = 1'b1
  } state_e;

  // Galois right-shift taps for x^8+x^6+x^5+x^4+1
  localparam logic [7:0] c_lfsr_taps = 8'hB8;

  // Number of set bits in a word of up to 32 bits
  function automatic logic [5:0] popcount(input logic [31:0] v);
    logic [5:0] n;
    n = '0;
    for (int i = 0; i < 32; i++) begin
      n = n + {5'b0, v[i]};
    end
    return n;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lfsr8.sv
`default_nettype none
// ============================================================================
// Module   : lfsr8
// Brief    : 8-bit Galois LFSR with synchronous load-to-seed and step enable.
// Revision : 1.0 - initial release
// ============================================================================
module lfsr8 #(
  parameter logic [7:0] LFSR_SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load_i,
  input  logic       step_i,
  output logic [7:0] lfsr_o
);
  import chan_pkg::*;

  logic [7:0] r_lfsr;
  logic [7:0] w_next;

  // Shift right and fold the taps back in when a one falls out of bit 0
  always_comb begin
    w_next = r_lfsr >> 1;
    if (r_lfsr[0]) begin
      w_next = (r_lfsr >> 1) ^ c_lfsr_taps;
    end
  end

  // Load has priority so a clear always lands on the seed
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_lfsr <= LFSR_SEED;
    end else if (load_i) begin
      r_lfsr <= LFSR_SEED;
    end else if (step_i) begin
      r_lfsr <= w_next;
    end
  end

  assign lfsr_o = r_lfsr;

endmodule
`default_nettype wire

// File: rtl/chan_err_inj.sv
`default_nettype none
// ============================================================================
// Module   : chan_err_inj
// Brief    : Noisy-channel model. Corrupts W-bit code symbols with periodic
//            or LFSR-random error bursts, reports the flipped bits and counts
//            injected bit errors over a programmable symbol window.
// Revision : 1.0 - initial release
// ============================================================================
module chan_err_inj #(
  parameter int         W           = 2,
  parameter int         PERIOD_LOG2 = 3,
  parameter int         MAX_BURST   = 4,
  parameter int         CNT_W       = 16,
  parameter logic [7:0] LFSR_SEED   = 8'hA5
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           clear_i,
  input  logic                           valid_i,
  input  logic [W-1:0]                   sym_i,
  input  logic [1:0]                     mode_i,
  input  logic [$clog2(MAX_BURST+1)-1:0] burst_len_i,
  input  logic [W-1:0]                   err_mask_i,
  input  logic [PERIOD_LOG2-1:0]         offset_i,
  input  logic [7:0]                     thresh_i,
  input  logic [CNT_W-1:0]               win_len_i,
  output logic                           valid_o,
  output logic [W-1:0]                   sym_o,
  output logic [W-1:0]                   err_o,
  output logic [CNT_W-1:0]               bad_bit_ct_o,
  output logic [CNT_W-1:0]               sym_ct_o,
  output logic                           win_done_o
);
  import chan_pkg::*;

  localparam int               c_burst_w = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] c_cnt_max = '1;

  // Burst FSM and symbol phase
  state_e                 r_state;
  logic [c_burst_w-1:0]   r_rem;
  logic [PERIOD_LOG2-1:0] r_phase;

  // Registered outputs and window bookkeeping
  logic                   r_valid;
  logic [W-1:0]           r_sym;
  logic [W-1:0]           r_err;
  logic [CNT_W-1:0]       r_bad;
  logic [CNT_W-1:0]       r_sym_ct;
  logic                   r_win_done;
  logic                   r_frozen;

  // Combinational decode
  logic [7:0]             w_lfsr;
  logic                   w_mode_on;
  logic                   w_trig;
  logic                   w_corrupt;
  logic [W-1:0]           w_err;
  logic [31:0]            w_err_ext;
  logic [5:0]             w_pc;
  logic [CNT_W-1:0]       w_sym_ct_next;
  logic [CNT_W:0]         w_bad_sum;
  logic [CNT_W-1:0]       w_bad_next;

  // The LFSR advances once per accepted symbol and is reseeded by clear
  lfsr8 #(
    .LFSR_SEED (LFSR_SEED)
  ) u_lfsr (
    .clk    (clk),
    .rst    (rst),
    .load_i (clear_i),
    .step_i (valid_i),
    .lfsr_o (w_lfsr)
  );

  // Trigger decode and the error pattern applied to the current symbol
  always_comb begin
    w_mode_on = (mode_i == MODE_PER) || (mode_i == MODE_RND);
    w_trig    = 1'b0;
    if (mode_i == MODE_PER) begin
      w_trig = (r_phase == offset_i);
    end else if (mode_i == MODE_RND) begin
      w_trig = (w_lfsr < thresh_i);
    end
    // An active burst keeps corrupting regardless of new triggers; a forced
    // off mode overrides everything for this very symbol.
    w_corrupt = w_mode_on &&
                ((r_state == BURST) || (w_trig && (burst_len_i != '0)));
    w_err     = w_corrupt ? err_mask_i : '0;
    w_err_ext = '0;
    w_err_ext[W-1:0] = w_err;
    w_pc      = popcount(w_err_ext);
  end

  // Saturating next values for both window counters
  always_comb begin
    w_sym_ct_next = (r_sym_ct == c_cnt_max) ? r_sym_ct : r_sym_ct + 1'b1;
    w_bad_sum     = {1'b0, r_bad} + (CNT_W+1)'(w_pc);
    w_bad_next    = w_bad_sum[CNT_W] ? c_cnt_max : w_bad_sum[CNT_W-1:0];
  end

  // Burst FSM: remaining count is latched at burst start so later changes
  // to burst_len_i do not stretch or cut an active burst
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= CLEAN;
      r_rem   <= '0;
      r_phase <= '0;
    end else if (clear_i) begin
      r_state <= CLEAN;
      r_rem   <= '0;
      r_phase <= '0;
    end else if (valid_i) begin
      r_phase <= r_phase + 1'b1;
      if (!w_mode_on) begin
        r_state <= CLEAN;
        r_rem   <= '0;
      end else begin
        case (r_state)
          CLEAN: begin
            if (w_trig && (burst_len_i != '0)) begin
              r_rem   <= burst_len_i - 1'b1;
              r_state <= (burst_len_i == c_burst_w'(1)) ? CLEAN : BURST;
            end
          end
          BURST: begin
            r_rem <= r_rem - 1'b1;
            if (r_rem == c_burst_w'(1)) begin
              r_state <= CLEAN;
            end
          end
          default: r_state <= CLEAN;
        endcase
      end
    end
  end

  // Output symbol path: one-cycle latency, symbol and error hold when idle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid <= 1'b0;
      r_sym   <= '0;
      r_err   <= '0;
    end else if (clear_i) begin
      r_valid <= 1'b0;
      r_sym   <= '0;
      r_err   <= '0;
    end else begin
      r_valid <= valid_i;
      if (valid_i) begin
        r_sym <= sym_i ^ w_err;
        r_err <= w_err;
      end
    end
  end

  // Window counters: freeze on completion, pulse done alongside valid_o
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sym_ct   <= '0;
      r_bad      <= '0;
      r_frozen   <= 1'b0;
      r_win_done <= 1'b0;
    end else if (clear_i) begin
      r_sym_ct   <= '0;
      r_bad      <= '0;
      r_frozen   <= 1'b0;
      r_win_done <= 1'b0;
    end else begin
      r_win_done <= 1'b0;
      if (valid_i && !r_frozen) begin
        r_sym_ct <= w_sym_ct_next;
        r_bad    <= w_bad_next;
        if ((win_len_i != '0) && (w_sym_ct_next == win_len_i)) begin
          r_frozen   <= 1'b1;
          r_win_done <= 1'b1;
        end
      end
    end
  end

  assign valid_o      = r_valid;
  assign sym_o        = r_sym;
  assign err_o        = r_err;
  assign bad_bit_ct_o = r_bad;
  assign sym_ct_o     = r_sym_ct;
  assign win_done_o   = r_win_done;

endmodule
`default_nettype wire
